ro_setassoc_cache: RTL
======================

RO_SETASSOC_CACHE -- requirements
Module: ro_setassoc_cache

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, associativity; power of 2, 1..8.
REQ-002 SHALL have parameter S_OFFSET, default 5, byte-offset bits; line = 2^S_OFFSET bytes, LINE_W = 8*2^S_OFFSET.
REQ-003 SHALL have parameter S_INDEX, default 3, index bits; NUM_SETS = 2^S_INDEX; tag = 32-S_OFFSET-S_INDEX bits.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cpu_read  in  1  read request; held with stable cpu_addr until cpu_resp.
REQ-007 cpu_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 cpu_rdata  out  32  selected word; 0 when cpu_resp low.
REQ-009 cpu_resp  out  1  one-cycle pulse; request complete.
REQ-010 flush  in  1  invalidate-all request, level-sampled.
REQ-011 mem_read  out  1  line fill request; held until mem_resp.
REQ-012 mem_addr  out  32  line-aligned fill address (offset bits 0); 0 when mem_read low.
REQ-013 mem_rdata  in  LINE_W  fill line, valid with mem_resp.
REQ-014 mem_resp  in  1  fill complete, one cycle.
REQ-015 hit_count, miss_count  out  32 each  performance counters.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, FLUSH.
REQ-017 Tag, valid, data lookup SHALL be combinational on cpu_addr; a hit in IDLE SHALL assert cpu_resp in the same cycle as cpu_read (0-cycle hit latency).
REQ-018 cpu_rdata SHALL be word cpu_addr[S_OFFSET-1:2] of the hit line, word 0 at bits [31:0].
REQ-019 Miss in IDLE: next state FILL; cpu_resp low; mem_read high from the next cycle, mem_addr = {cpu_addr[31:S_OFFSET], 0}.
REQ-020 In FILL on mem_resp: write mem_rdata, tag, valid=1 into the victim way of the indexed set; update PLRU; return to IDLE; the retried lookup hits next cycle (miss latency = memory latency + 2 cycles).
REQ-021 Victim: lowest-index invalid way, else the PLRU-selected way.
REQ-022 PLRU: tree of NUM_WAYS-1 bits per set; on every hit and fill, bits along the accessed way's path SHALL point away from it; NUM_WAYS=1 has no PLRU state, victim always way 0.
REQ-023 Multiple way hits are illegal; the lowest-index hit way SHALL be used.
REQ-024 flush in IDLE SHALL take priority over cpu_read: go to FLUSH, cpu_resp low that cycle.
REQ-025 FLUSH SHALL last one cycle: clear all NUM_SETS*NUM_WAYS valid bits and all PLRU bits, then return to IDLE.
REQ-026 flush during FILL SHALL be latched as pending; the fill completes normally and FLUSH is entered instead of IDLE.
REQ-027 hit_count SHALL increment on each cpu_resp from a first-lookup hit; miss_count on each IDLE->FILL transition; both wrap 0xFFFFFFFF->0.
REQ-028 Post-fill hits SHALL not count as hits.

Reset
REQ-029 On rst: state IDLE, all valid and PLRU bits 0, pending flush 0, counters 0.
REQ-030 On rst: cpu_resp, mem_read 0; cpu_rdata, mem_addr 0.
REQ-031 rst asserted mid-FILL SHALL drop mem_read immediately (asynchronously); a late mem_resp after reset SHALL be ignored.
REQ-032 Data and tag arrays need not be reset.

Structure
REQ-033 Package ro_cache_pkg SHALL hold the FSM state enum and the MAX_WAYS=8 constant.
REQ-034 PLRU update and victim logic SHALL be a sub-module plru_tree, parametrised by NUM_WAYS.

Verification
REQ-035 Cold read 0x0000_1014, fill line words k=0xA0+k -> mem_addr 0x0000_1000, cpu_rdata 0xA5, miss_count 1; re-read -> same-cycle resp, hit_count 1.
REQ-036 Fill set 0 with 0x000/0x100/0x200/0x300, touch in that order, read 0x400 -> way 0 evicted; re-read 0x000 misses, 0x100 hits.
REQ-037 flush and cpu_read same IDLE cycle -> no resp, FLUSH one cycle; prior cached 0x1014 then misses.
REQ-038 flush pulse mid-FILL -> fill completes, FLUSH next, all lines invalid afterwards.
REQ-039 rst two cycles into FILL -> mem_read 0 same cycle, counters 0, later mem_resp causes no write.
REQ-040 NUM_WAYS=1 and NUM_WAYS=8 builds: conflicting addresses 0x000/0x100 thrash (NUM_WAYS=1) vs. eight lines co-resident (NUM_WAYS=8).

Source files
------------

// File: rtl/ro_cache_pkg.sv
// Shared types and sizing helpers for the read-only set-associative cache.
// Tree-PLRU storage is NUM_WAYS-1 bits per set; a direct-mapped build keeps one dummy bit.
package ro_cache_pkg;

    localparam int MAX_WAYS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } cache_state_e;

    function automatic int way_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tree_bits(input int n);
        return (n > 1) ? n - 1 : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim choice (first invalid way, else tree walk)
// and the updated tree after touching either the requested way or the victim.
module plru_tree
    import ro_cache_pkg::*;
#(
    parameter int  NUM_WAYS = 4,
    localparam int WAY_W    = way_bits(NUM_WAYS),
    localparam int TREE_W   = tree_bits(NUM_WAYS)
) (
    input  logic [TREE_W-1:0]   tree_in,
    input  logic [NUM_WAYS-1:0] valid_in,
    input  logic [WAY_W-1:0]    access_way,
    input  logic                use_victim,
    output logic [WAY_W-1:0]    victim,
    output logic [TREE_W-1:0]   tree_out
);

    if (NUM_WAYS == 1) begin : g_direct
        logic unused_in;
        assign unused_in = ^{tree_in, valid_in, access_way, use_victim};
        assign victim    = '0;
        assign tree_out  = '0;
    end else begin : g_tree
        localparam int LEVELS = WAY_W;
        logic [WAY_W-1:0] lru_way;
        logic [WAY_W-1:0] acc_way;

        // Heap layout: node n has children 2n+1 (bit=0, left) and 2n+2 (bit=1, right).
        always_comb begin
            int node;
            node    = 0;
            lru_way = '0;
            for (int l = 0; l < LEVELS; l++) begin
                lru_way[LEVELS-1-l] = tree_in[node];
                node = 2 * node + 1 + int'(tree_in[node]);
            end
        end

        always_comb begin
            victim = lru_way;
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (!valid_in[w]) begin
                    victim = WAY_W'(w);
                end
            end
        end

        assign acc_way = use_victim ? victim : access_way;

        always_comb begin
            int node;
            node     = 0;
            tree_out = tree_in;
            for (int l = 0; l < LEVELS; l++) begin
                node = (1 << l) - 1 + int'(acc_way >> (LEVELS - l));
                tree_out[node] = ~acc_way[LEVELS-1-l];
            end
        end
    end

endmodule

// File: rtl/ro_setassoc_cache.sv
// Read-only set-associative cache with combinational lookup, tree-PLRU
// replacement, single-cycle flush and hit/miss performance counters.
//   state    | meaning
//   ST_IDLE  | lookup on cpu_read; hit answers same cycle, miss starts a fill
//   ST_FILL  | mem_read held; on mem_resp write victim way, then IDLE or FLUSH
//   ST_FLUSH | one cycle: clear every valid and PLRU bit
module ro_setassoc_cache
    import ro_cache_pkg::*;
#(
    parameter int  NUM_WAYS = 4,
    parameter int  S_OFFSET = 5,
    parameter int  S_INDEX  = 3,
    localparam int LINE_W   = 8 * (1 << S_OFFSET)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic [31:0]       cpu_addr,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_resp,
    input  logic              flush,
    output logic              mem_read,
    output logic [31:0]       mem_addr,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int NUM_SETS = 1 << S_INDEX;
    localparam int TAG_W    = 32 - S_OFFSET - S_INDEX;
    localparam int WORDS    = 1 << (S_OFFSET - 2);
    localparam int WAY_W    = way_bits(NUM_WAYS);
    localparam int TREE_W   = tree_bits(NUM_WAYS);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    cache_state_e state_q, state_d;
    logic         pend_q, pend_d;
    logic         retry_q, retry_d;
    logic         mem_read_q, mem_read_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [31:0]  hit_cnt_q, hit_cnt_d;
    logic [31:0]  miss_cnt_q, miss_cnt_d;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
    logic [TREE_W-1:0]   plru_q  [NUM_SETS];
    logic [TREE_W-1:0]   plru_d  [NUM_SETS];

    logic [TAG_W-1:0]  tag_arr  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] data_arr [NUM_SETS][NUM_WAYS];

    logic [S_INDEX-1:0]  cpu_idx, fill_idx, plru_set;
    logic [TAG_W-1:0]    cpu_tag, fill_tag;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way, victim_way;
    logic [TREE_W-1:0]   plru_upd;
    logic [LINE_W-1:0]   hit_line;
    logic [31:0]         word_idx, line_word;
    logic                fill_we;

    assign cpu_idx  = cpu_addr[S_OFFSET +: S_INDEX];
    assign cpu_tag  = cpu_addr[31 -: TAG_W];
    assign fill_idx = mem_addr_q[S_OFFSET +: S_INDEX];
    assign fill_tag = mem_addr_q[31 -: TAG_W];

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[cpu_idx][w] && (tag_arr[cpu_idx][w] == cpu_tag);
        end
        hit     = |hit_vec;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line  = data_arr[cpu_idx][hit_way];
    assign word_idx  = (cpu_addr >> 2) & 32'(WORDS - 1);
    assign line_word = 32'(hit_line >> (word_idx * 32'd32));

    assign cpu_resp   = (state_q == ST_IDLE) && cpu_read && !flush && hit;
    assign cpu_rdata  = cpu_resp ? line_word : 32'h0;
    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // The fill address register also selects the set being filled, so the
    // fill does not depend on cpu_addr staying stable.
    assign plru_set = (state_q == ST_FILL) ? fill_idx : cpu_idx;

    plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .tree_in    (plru_q[plru_set]),
        .valid_in   (valid_q[plru_set]),
        .access_way (hit_way),
        .use_victim (state_q == ST_FILL),
        .victim     (victim_way),
        .tree_out   (plru_upd)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        retry_d    = 1'b0;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        plru_d     = plru_q;
        fill_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (cpu_read) begin
                    if (hit) begin
                        plru_d[cpu_idx] = plru_upd;
                        // retry_q marks the lookup replayed right after a fill
                        if (!retry_q) begin
                            hit_cnt_d = hit_cnt_q + 32'd1;
                        end
                    end else begin
                        state_d    = ST_FILL;
                        mem_read_d = 1'b1;
                        mem_addr_d = cpu_addr & LINE_MASK;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                end
            end
            ST_FILL: begin
                if (flush) begin
                    pend_d = 1'b1;
                end
                if (mem_resp) begin
                    fill_we                      = 1'b1;
                    valid_d[fill_idx][victim_way] = 1'b1;
                    plru_d[fill_idx]             = plru_upd;
                    mem_read_d                   = 1'b0;
                    mem_addr_d                   = 32'h0;
                    retry_d                      = 1'b1;
                    pend_d                       = 1'b0;
                    state_d = (pend_q || flush) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_d[s] = '0;
                    plru_d[s]  = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            retry_q    <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= 32'h0;
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
            valid_q    <= '{default: '0};
            plru_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            retry_q    <= retry_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            plru_q     <= plru_d;
        end
    end

    // Line storage has no reset; valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_arr[fill_idx][victim_way] <= mem_rdata;
            tag_arr[fill_idx][victim_way]  <= fill_tag;
        end
    end

endmodule
